seq_shift_unit: RTL and testbench

//   Multi-cycle, parametrised shifter: loads a WIDTH-bit operand, shifts it by one

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_step.sv | 30 +++
 rtl/seq_shift_unit.sv | 100 ++++++++++
 tb/tb_seq_shift_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shift-mode codes and FSM state encoding for seq_shift_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// shift_step : combinational one-position shifter (SLL/SRL/SRA/ROL)
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = r;
    case (mode)
      SH_SLL:  next = {r[WIDTH-2:0], 1'b0};
      SH_SRL:  next = {1'b0, r[WIDTH-1:1]};
      SH_SRA:  next = {r[WIDTH-1], r[WIDTH-1:1]};
      SH_ROL:  next = {r[WIDTH-2:0], r[WIDTH-1]};
      default: next = r;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// ============================================================================
// seq_shift_unit : multi-cycle shifter, one position per clock, start/busy/done
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [AMT_W:0] C_AMT_MAX = (AMT_W + 1)'(WIDTH - 1);

  state_t           r_state;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_reg;
  logic [1:0]       r_mode;
  logic             r_busy;
  logic             r_done;

  logic [AMT_W-1:0] w_amt;
  logic [WIDTH-1:0] w_next;

  // Only reachable when WIDTH is not a power of two.
  assign w_amt = ({1'b0, amt} > C_AMT_MAX) ? C_AMT_MAX[AMT_W-1:0] : amt;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r    (r_reg),
    .mode (r_mode),
    .next (w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_reg   <= '0;
      r_mode  <= SH_SLL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_reg  <= data_in;
            r_cnt  <= w_amt;
            r_mode <= mode;
            r_busy <= 1'b1;
            if (w_amt == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_reg <= w_next;
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_reg;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// ============================================================================
// tb_seq_shift_unit : scoreboard-based bench for seq_shift_unit (WIDTH=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_shift_unit;
  import shift_pkg::*;

  localparam int W = 8;
  localparam int A = 3;
  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [A-1:0] amt = '0;
  logic [1:0]   mode = SH_SLL;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb_q[$];

  seq_shift_unit #(.WIDTH(W), .AMT_W(A)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .amt      (amt),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Reference: whole shift in one operator, not iterated single steps.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int n, input logic [1:0] m);
    case (m)
      SH_SLL:  return d << n;
      SH_SRL:  return d >> n;
      SH_SRA:  return W'($signed(d) >>> n);
      default: return (n == 0) ? d : W'((d << n) | (d >> (W - n)));
    endcase
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_op(input logic [W-1:0] d, input int n, input logic [1:0] m);
    data_in = d;
    amt     = A'(n);
    mode    = m;
    start   = 1'b1;
    sb_q.push_back(model(d, n, m));
    @(negedge clk);
    start   = 1'b0;
    data_in = W'($urandom);
    amt     = A'($urandom);
    mode    = 2'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bcnt, output bit tmo);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < TMO) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (done) bcnt++;
    tmo = !done;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, data_out} !== {1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b data_out=%h, required 0 0 00", busy, done, data_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Run one operation and score result, latency and busy duration.
  task automatic test_op(input string name, input logic [W-1:0] d, input int n, input logic [1:0] m);
    int cyc, bcnt;
    bit tmo;
    logic [W-1:0] exp;
    start_op(d, n, m);
    wait_done(cyc, bcnt, tmo);
    checks++;
    if (tmo) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, TMO);
      sb_q.delete();
      return;
    end
    exp = sb_q.pop_front();
    checks++;
    if (data_out !== exp) begin
      failures++;
      $display("FAIL %s_data: data_out=%h, required %h", name, data_out, exp);
    end
    checks++;
    if (cyc != n || bcnt != n + 1) begin
      failures++;
      $display("FAIL %s_latency: done after %0d cycles busy %0d, required %0d and %0d", name, cyc, bcnt, n, n + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data_out !== exp) begin
      failures++;
      $display("FAIL %s_after: done=%b busy=%b data_out=%h, required 0 0 %h", name, done, busy, data_out, exp);
    end
  endtask

  task automatic test_modes;
    test_op("sll", 8'b1011_0011, 3, SH_SLL);
    test_op("sra", 8'b1000_0100, 2, SH_SRA);
    test_op("srl", 8'hFF, 7, SH_SRL);
    test_op("rol4", 8'hA5, 4, SH_ROL);
    test_op("rol1", 8'h81, 1, SH_ROL);
    test_op("amt0", 8'h3C, 0, SH_SRL);
  endtask

  task automatic test_busy_ignore;
    int dcnt;
    int cyc;
    start_op(8'h01, 5, SH_SLL);
    data_in = 8'hF0;
    amt     = 3'd1;
    mode    = SH_SRL;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dcnt++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL ignore_extra_done: done with empty scoreboard, data_out=%h", data_out);
        end else if (data_out !== sb_q[0]) begin
          failures++;
          $display("FAIL ignore_data: data_out=%h, required %h", data_out, sb_q[0]);
        end
        if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
      @(negedge clk);
    end
    checks++;
    if (dcnt != 1) begin
      failures++;
      $display("FAIL ignore_done_count: %0d done pulses, required 1", dcnt);
    end
    sb_q.delete();
  endtask

  task automatic test_reset_abort;
    int dcnt;
    start_op(8'h5B, 6, SH_SLL);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, data_out} !== {1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL abort_state: busy=%b done=%b data_out=%h, required 0 0 00", busy, done, data_out);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (dcnt != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with done/busy after abort, required 0", dcnt);
    end
    test_op("post_abort", 8'hC3, 3, SH_SRA);
  endtask

  task automatic test_back_to_back;
    int dcnt;
    int first;
    // Reassert start in the IDLE cycle right after done falls.
    test_op("b2b_a", 8'h96, 2, SH_SRL);
    test_op("b2b_b", 8'h69, 5, SH_ROL);
    // Held start re-triggers every amt+2 cycles.
    data_in = 8'h81;
    amt     = 3'd1;
    mode    = SH_ROL;
    start   = 1'b1;
    dcnt  = 0;
    first = -1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (first < 0) first = i;
        checks++;
        if (data_out !== 8'h03) begin
          failures++;
          $display("FAIL held_data: data_out=%h, required 03", data_out);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dcnt != 3 || first != 1) begin
      failures++;
      $display("FAIL held_retrigger: %0d pulses first at %0d, required 3 first at 1", dcnt, first);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_modes();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
